// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the RISC datapath controller.
// Holds the FSM state enum, instruction opcode/op codes and the datapath control codes.
package ctrl_pkg;

    localparam int CTRL_DW  = 16;
    localparam int CTRL_RNW = 3;

    typedef enum logic [2:0] {
        WAIT,
        DECODE,
        GET_A,
        GET_B,
        ALU,
        WRITE_REG,
        WRITE_IMM
    } state_t;

    // opcode = IR[15:13], op = IR[12:11]
    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL1 = 2'b01;
    localparam logic [1:0] SH_LSR1 = 2'b10;
    localparam logic [1:0] SH_ASR1 = 2'b11;

endpackage

// File: rtl/instr_dec.sv
// Instruction field decoder: splits IR into register numbers, shift, sign-extended imm8 and a one-hot class.
// Purely combinational (0 cycles); no flow control.
module instr_dec
    import ctrl_pkg::*;
#(
    parameter int DW  = CTRL_DW,
    parameter int RNW = CTRL_RNW
) (
    input  logic [DW-1:0]  ir,
    output logic [RNW-1:0] rn,
    output logic [RNW-1:0] rd,
    output logic [RNW-1:0] rm,
    output logic [1:0]     sh,
    output logic [DW-1:0]  sximm8,
    output logic           movi,
    output logic           movr,
    output logic           add,
    output logic           cmp,
    output logic           and_op,
    output logic           mvn,
    output logic           illegal
);

    logic [2:0] opcode;
    logic [1:0] op;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = {{(DW-8){ir[7]}}, ir[7:0]};

    assign movi   = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
    assign movr   = (opcode == OPC_MOV) && (op == OP_MOV_REG);
    assign add    = (opcode == OPC_ALU) && (op == OP_ADD);
    assign cmp    = (opcode == OPC_ALU) && (op == OP_CMP);
    assign and_op = (opcode == OPC_ALU) && (op == OP_AND);
    assign mvn    = (opcode == OPC_ALU) && (op == OP_MVN);

    // Everything not matched above, including 110/01 and 110/11.
    assign illegal = ~(movi | movr | add | cmp | and_op | mvn);

endmodule

// File: rtl/datapath_ctrl.sv
// Moore FSM sequencing the register/shifter/ALU datapath through one latched instruction.
// Latency from start accept to ready: MOV imm 3, MOV reg/MVN/CMP 5, ADD/AND 6, illegal 2 edges.
// Start is only sampled while ready (w=1); start/instr during a busy instruction are ignored.
module datapath_ctrl
    import ctrl_pkg::*;
#(
    parameter int DW  = CTRL_DW,
    parameter int RNW = CTRL_RNW
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           s,
    input  logic [DW-1:0]  instr,
    output logic           w,
    output logic           err_illegal,
    output logic           vsel,
    output logic [RNW-1:0] writenum,
    output logic           write,
    output logic [RNW-1:0] readnum,
    output logic           loada,
    output logic           loadb,
    output logic [1:0]     shift,
    output logic           asel,
    output logic           bsel,
    output logic [1:0]     ALUop,
    output logic           loadc,
    output logic           loads,
    output logic [DW-1:0]  datapath_in
);

    state_t         state;
    state_t         state_nx;
    logic [DW-1:0]  ir;

    logic [RNW-1:0] rn;
    logic [RNW-1:0] rd;
    logic [RNW-1:0] rm;
    logic [1:0]     sh;
    logic [DW-1:0]  sximm8;
    logic           movi;
    logic           movr;
    logic           add;
    logic           cmp;
    logic           and_op;
    logic           mvn;
    logic           illegal;

    instr_dec #(
        .DW  (DW),
        .RNW (RNW)
    ) u_dec (
        .ir      (ir),
        .rn      (rn),
        .rd      (rd),
        .rm      (rm),
        .sh      (sh),
        .sximm8  (sximm8),
        .movi    (movi),
        .movr    (movr),
        .add     (add),
        .cmp     (cmp),
        .and_op  (and_op),
        .mvn     (mvn),
        .illegal (illegal)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= WAIT;
        end else begin
            state <= state_nx;
        end
    end

    // IR only opens in WAIT, so instr wiggling while busy never reaches the decoder.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir <= '0;
        end else if ((state == WAIT) && s) begin
            ir <= instr;
        end
    end

    always_comb begin
        state_nx    = state;
        w           = 1'b0;
        err_illegal = 1'b0;
        vsel        = 1'b0;
        writenum    = '0;
        write       = 1'b0;
        readnum     = '0;
        loada       = 1'b0;
        loadb       = 1'b0;
        shift       = SH_NONE;
        asel        = 1'b0;
        bsel        = 1'b0;
        ALUop       = ALU_ADD;
        loadc       = 1'b0;
        loads       = 1'b0;
        datapath_in = '0;

        case (state)
            WAIT: begin
                w = 1'b1;
                if (s) begin
                    state_nx = DECODE;
                end
            end

            DECODE: begin
                if (movi) begin
                    state_nx = WRITE_IMM;
                end else if (movr || mvn) begin
                    state_nx = GET_B;
                end else if (add || cmp || and_op) begin
                    state_nx = GET_A;
                end else begin
                    err_illegal = illegal;
                    state_nx    = WAIT;
                end
            end

            GET_A: begin
                readnum  = rn;
                loada    = 1'b1;
                state_nx = GET_B;
            end

            GET_B: begin
                readnum  = rm;
                loadb    = 1'b1;
                state_nx = ALU;
            end

            ALU: begin
                shift = sh;
                if (cmp) begin
                    // Compare only updates status; C and the register file stay untouched.
                    ALUop    = ALU_SUB;
                    loads    = 1'b1;
                    state_nx = WAIT;
                end else begin
                    loadc    = 1'b1;
                    state_nx = WRITE_REG;
                    if (movr) begin
                        asel  = 1'b1;
                        ALUop = ALU_ADD;
                    end else if (mvn) begin
                        asel  = 1'b1;
                        ALUop = ALU_NOTB;
                    end else if (and_op) begin
                        ALUop = ALU_AND;
                    end else begin
                        ALUop = ALU_ADD;
                    end
                end
            end

            WRITE_REG: begin
                vsel     = 1'b0;
                writenum = rd;
                write    = 1'b1;
                state_nx = WAIT;
            end

            WRITE_IMM: begin
                vsel        = 1'b1;
                writenum    = rn;
                datapath_in = sximm8;
                write       = 1'b1;
                state_nx    = WAIT;
            end

            default: begin
                state_nx = WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: per-cycle strobe scoreboard plus a behavioural datapath for register results.
module tb_datapath_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        s = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        w, err_illegal, vsel, write, loada, loadb, asel, bsel, loadc, loads;
    logic [2:0]  writenum, readnum;
    logic [1:0]  shift, ALUop;
    logic [15:0] datapath_in;

    datapath_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s           (s),
        .instr       (instr),
        .w           (w),
        .err_illegal (err_illegal),
        .vsel        (vsel),
        .writenum    (writenum),
        .write       (write),
        .readnum     (readnum),
        .loada       (loada),
        .loadb       (loadb),
        .shift       (shift),
        .asel        (asel),
        .bsel        (bsel),
        .ALUop       (ALUop),
        .loadc       (loadc),
        .loads       (loads),
        .datapath_in (datapath_in)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        w;
        logic        err;
        logic        vsel;
        logic [2:0]  wn;
        logic        wr;
        logic [2:0]  rn;
        logic        la;
        logic        lb;
        logic [1:0]  sh;
        logic        asel;
        logic        bsel;
        logic [1:0]  aluop;
        logic        lc;
        logic        ls;
        logic [15:0] dp;
    } obs_t;

    typedef struct {
        obs_t  o;
        bit    dp_chk;
        string nm;
    } exp_t;

    typedef struct {
        logic [15:0] ins;
        int          chk_reg;
        logic [15:0] val;
        string       nm;
    } vec_t;

    obs_t act;
    assign act = {w, err_illegal, vsel, writenum, write, readnum, loada, loadb,
                  shift, asel, bsel, ALUop, loadc, loads, datapath_in};

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Behavioural datapath driven by the controller outputs.
    logic [15:0] rf [8];
    logic [15:0] ra, rb, rc, bsh, ain, alu;
    logic        zflag;

    always_comb begin
        case (shift)
            2'b00:   bsh = rb;
            2'b01:   bsh = {rb[14:0], 1'b0};
            2'b10:   bsh = {1'b0, rb[15:1]};
            default: bsh = {rb[15], rb[15:1]};
        endcase
        ain = asel ? 16'h0000 : ra;
        case (ALUop)
            2'b00:   alu = ain + bsh;
            2'b01:   alu = ain - bsh;
            2'b10:   alu = ain & bsh;
            default: alu = ~bsh;
        endcase
    end

    always @(posedge clk) begin
        if (write) rf[writenum] <= vsel ? datapath_in : rc;
        if (loada) ra <= rf[readnum];
        if (loadb) rb <= rf[readnum];
        if (loadc) rc <= alu;
        if (loads) zflag <= (alu == 16'h0000);
    end

    function automatic obs_t idle_obs();
        obs_t o;
        o = '0;
        o.w = 1'b1;
        return o;
    endfunction

    function automatic exp_t mk(input obs_t o, input bit d, input string n);
        exp_t e;
        e.o = o;
        e.dp_chk = d;
        e.nm = n;
        return e;
    endfunction

    // Expected per-cycle outputs after the accept edge, ending with the WAIT cycle.
    task automatic push_exp(input logic [15:0] x);
        logic [2:0] opc, rn, rd, rm;
        logic [1:0] op, sh;
        bit movi, movr, add, cmp, andi, mvn, ill;
        obs_t o;
        opc = x[15:13]; op = x[12:11]; rn = x[10:8]; rd = x[7:5]; sh = x[4:3]; rm = x[2:0];
        movi = (opc == 3'b110) && (op == 2'b10);
        movr = (opc == 3'b110) && (op == 2'b00);
        add  = (opc == 3'b101) && (op == 2'b00);
        cmp  = (opc == 3'b101) && (op == 2'b01);
        andi = (opc == 3'b101) && (op == 2'b10);
        mvn  = (opc == 3'b101) && (op == 2'b11);
        ill  = !(movi || movr || add || cmp || andi || mvn);
        o = '0; o.err = ill;
        exp_q.push_back(mk(o, 1'b0, "decode"));
        if (movi) begin
            o = '0; o.vsel = 1'b1; o.wn = rn; o.wr = 1'b1; o.dp = {{8{x[7]}}, x[7:0]};
            exp_q.push_back(mk(o, 1'b1, "write_imm"));
        end else if (!ill) begin
            if (add || cmp || andi) begin
                o = '0; o.rn = rn; o.la = 1'b1;
                exp_q.push_back(mk(o, 1'b0, "get_a"));
            end
            o = '0; o.rn = rm; o.lb = 1'b1;
            exp_q.push_back(mk(o, 1'b0, "get_b"));
            o = '0; o.sh = sh;
            if (movr)      begin o.asel = 1'b1; o.aluop = 2'b00; o.lc = 1'b1; end
            else if (mvn)  begin o.asel = 1'b1; o.aluop = 2'b11; o.lc = 1'b1; end
            else if (add)  begin o.aluop = 2'b00; o.lc = 1'b1; end
            else if (andi) begin o.aluop = 2'b10; o.lc = 1'b1; end
            else           begin o.aluop = 2'b01; o.ls = 1'b1; end
            exp_q.push_back(mk(o, 1'b0, "alu"));
            if (!cmp) begin
                o = '0; o.wn = rd; o.wr = 1'b1;
                exp_q.push_back(mk(o, 1'b0, "write_reg"));
            end
        end
        exp_q.push_back(mk(idle_obs(), 1'b0, "wait"));
    endtask

    task automatic cmp_obs(input string nm, input obs_t e, input bit dp_chk);
        obs_t a, x;
        a = act;
        x = e;
        if (!dp_chk) begin
            a.dp = 16'h0000;
            x.dp = 16'h0000;
        end
        checks++;
        if (a !== x) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, a, x);
        end
    endtask

    task automatic cmp_val(input string nm, input logic [15:0] a, input logic [15:0] x);
        checks++;
        if (a !== x) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, a, x);
        end
    endtask

    // Scoreboard pop: one record per clock while an instruction is in flight.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp_obs(e.nm, e.o, e.dp_chk);
        end
    end

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=%0d_pending required=0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic issue(input logic [15:0] x, input string nm);
        @(negedge clk);
        s = 1'b1;
        instr = x;
        @(posedge clk);
        push_exp(x);
        @(negedge clk);
        s = 1'b0;
        instr = 16'($urandom);
        wait_drain(nm);
    endtask

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{16'hD007, 0, 16'h0007, "mov_r0_7"};
        tbl[1]  = '{16'hD102, 1, 16'h0002, "mov_r1_2"};
        tbl[2]  = '{16'hA148, 2, 16'h0010, "add_r2_lsl"};
        tbl[3]  = '{16'hD1FE, 1, 16'hFFFE, "mov_r1_m2"};
        tbl[4]  = '{16'hA801, 8, 16'h0000, "cmp_r0_r1"};
        tbl[5]  = '{16'h0000, -1, 16'h0000, "illegal_0000"};
        tbl[6]  = '{16'hC068, 3, 16'h000E, "movr_r3_lsl"};
        tbl[7]  = '{16'hB883, 4, 16'hFFF1, "mvn_r4"};
        tbl[8]  = '{16'hB3B0, 5, 16'h0002, "and_r5_lsr"};
        tbl[9]  = '{16'hC0DC, 6, 16'hFFF8, "movr_r6_asr"};
        tbl[10] = '{16'hD780, 7, 16'hFF80, "mov_imm_80"};
        tbl[11] = '{16'hD67F, 6, 16'h007F, "mov_imm_7f"};
        tbl[12] = '{16'hA242, 2, 16'h0020, "add_same_reg"};
        tbl[13] = '{16'hC800, -1, 16'h0000, "illegal_c800"};
        tbl[14] = '{16'hA800, 8, 16'h0001, "cmp_equal"};
        tbl[15] = '{16'hE000, -1, 16'h0000, "illegal_e000"};

        #12;
        cmp_obs("reset_state", idle_obs(), 1'b1);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            issue(tbl[i].ins, tbl[i].nm);
            if (tbl[i].chk_reg == 8) begin
                cmp_val({tbl[i].nm, "_z"}, {15'h0, zflag}, tbl[i].val);
            end else if (tbl[i].chk_reg >= 0) begin
                cmp_val({tbl[i].nm, "_reg"}, rf[tbl[i].chk_reg], tbl[i].val);
            end
        end

        // Async reset while an ADD R2,R1,R1 sits in GET_B; the write must never happen.
        @(negedge clk);
        s = 1'b1;
        instr = 16'hA141;
        @(posedge clk);
        @(negedge clk);
        s = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        cmp_val("pre_reset_get_b", {11'h0, loadb, readnum, w}, {11'h0, 1'b1, 3'd1, 1'b0});
        #1;
        reset_n = 1'b0;
        #1;
        cmp_obs("async_reset_idle", idle_obs(), 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        cmp_val("no_resume_r2", rf[2], 16'h0020);
        cmp_val("idle_after_reset", {15'h0, w}, 16'h0001);

        // s held high: second instruction accepted on the first WAIT edge; busy instr ignored.
        @(negedge clk);
        s = 1'b1;
        instr = 16'hD007;
        @(posedge clk);
        push_exp(16'hD007);
        push_exp(16'hD102);
        @(negedge clk);
        instr = 16'hD3AA;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        instr = 16'hD102;
        @(posedge clk);
        @(negedge clk);
        s = 1'b0;
        instr = 16'($urandom);
        wait_drain("back_to_back");
        cmp_val("b2b_r0", rf[0], 16'h0007);
        cmp_val("b2b_r1", rf[1], 16'h0002);
        cmp_val("b2b_r3_untouched", rf[3], 16'h000E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/datapath_ctrl.md
Name: datapath_ctrl

Overview:
Moore FSM controller that sequences the 16-bit register/shifter/ALU datapath through a single instruction.
- Latches a 16-bit instruction on a start handshake.
- Decodes it and drives every datapath control input cycle by cycle.
- Raises w (ready) when the datapath is idle.
- Sits directly above the datapath in the simple RISC machine and replaces the bench-driven control sequences.

Parameters:
- DW, 16, instruction width and datapath_in width.
- RNW, 3, register number width; 8 registers.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- s  in  1  start; sampled only in WAIT
- instr  in  DW  instruction; captured into IR when s=1 in WAIT
- w  out  1  ready; 1 only in WAIT
- err_illegal  out  1  one-cycle pulse in DECODE on an undefined encoding
- vsel  out  1  1 selects datapath_in for writeback, 0 selects C
- writenum  out  RNW  register to write
- write  out  1  register-file write enable
- readnum  out  RNW  register-file read select (combinational read)
- loada, loadb  out  1  A and B pipeline register enables
- shift  out  2  shifter op: 00 none, 01 LSL1, 10 LSR1, 11 ASR1
- asel  out  1  1 forces ALU A input to 0
- bsel  out  1  held 0 (shifter output selected)
- ALUop  out  2  00 ADD, 01 SUB, 10 AND, 11 NOT B
- loadc, loads  out  1  C register and status register enables
- datapath_in  out  DW  sign-extended imm8 (IR[7:0] extended to DW bits)

Behaviour:
Decisions:
- Clock is clk; reset is reset_n, asynchronous, active-low.
- IR fields:
  - opcode = IR[15:13]
  - op = IR[12:11]
  - Rn = IR[10:8]
  - Rd = IR[7:5]
  - sh = IR[4:3]
  - Rm = IR[2:0]
  - imm8 = IR[7:0]
- Encodings:
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm{sh}
  - 101/00 ADD Rd,Rn,Rm{sh}
  - 101/01 CMP Rn,Rm{sh}
  - 101/10 AND Rd,Rn,Rm{sh}
  - 101/11 MVN Rd,Rm{sh}
  - Any other opcode/op pair is illegal.

Reset state:
- reset_n=0 immediately forces state WAIT, IR=0, w=1.
- All strobes (write, loada, loadb, loadc, loads, err_illegal) = 0.
- vsel, asel, bsel, shift, ALUop, readnum, writenum = 0.
- This holds mid-instruction: no partial write completes after reset asserts.

Outputs and strobes:
- All outputs are decoded from state plus IR; no output depends on s or instr combinationally.
- Strobes are high only in the states listed below.

States and transitions:
- WAIT: w=1. On s=1, IR<=instr and go to DECODE; else stay.
- DECODE:
  - MOV imm -> WRITE_IMM
  - MOV reg or MVN -> GET_B
  - ADD, CMP, AND -> GET_A
  - Illegal -> WAIT, with err_illegal=1 this cycle.
- GET_A: readnum=Rn, loada=1 -> GET_B.
- GET_B: readnum=Rm, loadb=1 -> ALU.
- ALU: shift=sh.
  - MOV reg: asel=1, ALUop=00, loadc=1 -> WRITE_REG.
  - MVN: asel=1, ALUop=11, loadc=1 -> WRITE_REG.
  - ADD: ALUop=00, loadc=1 -> WRITE_REG.
  - AND: ALUop=10, loadc=1 -> WRITE_REG.
  - CMP: ALUop=01, loads=1, loadc=0 -> WAIT.
- WRITE_REG: vsel=0, writenum=Rd, write=1 -> WAIT.
- WRITE_IMM: vsel=1, writenum=Rn, datapath_in=sext(imm8), write=1 -> WAIT.

Latency (clock edges from s-accept to w=1):
- MOV imm: 3
- MOV reg / MVN: 5
- ADD / AND: 6
- CMP: 5
- Illegal: 2

Boundary conditions:
- s while w=0 is ignored; instr changes while busy do not affect IR.
- s held high continuously: the next instruction is accepted on the first edge in WAIT, giving back-to-back operation.
- imm8 = 0x80 produces datapath_in = 0xFF80; imm8 = 0x7F produces 0x007F.
- Rd = Rn = Rm (same register) is legal. GET_A and GET_B read before WRITE_REG, so no hazard exists.

Decomposition:
- Package ctrl_pkg holds:
  - state enum: WAIT, DECODE, GET_A, GET_B, ALU, WRITE_REG, WRITE_IMM
  - opcode/op localparams
  - ALUop and shift localparams
- Sub-module instr_dec: combinational IR-to-fields decoder. Produces Rn, Rd, Rm, sh, sximm8 and the one-hot instruction class (movi, movr, add, cmp, and, mvn, illegal).

Test Plan:
- Reset, then s=1 with instr=16'hD007 (MOV R0,#7) -> in WRITE_IMM: write=1, vsel=1, writenum=0, datapath_in=16'h0007; w=1 after 3 edges. With the datapath attached, R0=7.
- Load R1 with 16'hD102 (MOV R1,#2), then 16'hA148 (ADD R2,R1,R0,LSL#1) -> strobe sequence:
  - readnum=1 with loada
  - readnum=0 with loadb
  - shift=01, ALUop=00, loadc
  - writenum=2, vsel=0, write
  - Result R2=16; w returns after 6 edges.
- 16'hD1FE (MOV R1,#-2) -> datapath_in=16'hFFFE. Then 16'hA801 (CMP R0,R1) -> loads=1, ALUop=01, loadc never 1, write never 1 during the instruction; WAIT after 5 edges.
- instr=16'h0000 (illegal) -> err_illegal high exactly one cycle, no write or load strobe, w=1 after 2 edges.
- reset_n=0 asynchronously while in GET_B during an ADD -> w=1 and all strobes 0 before the next clk edge. After release, the ADD is not resumed: no write to R2.
- s held at 1 with 16'hD007 then 16'hD102 presented back-to-back -> second instr accepted on the first WAIT edge. instr changes while w=0 are ignored (IR unchanged, verified by writenum).
